// File: rtl/button_step_conditioner.sv
// button_step_conditioner
// Push-button front end for the sequencing FSM. It synchronises the raw
// active-low key, debounces it, and emits one single-cycle `step` pulse per
// accepted press. It also drives a one-shot LED acknowledge blink
// (BLINK_CYCLES on, then BLINK_CYCLES off).
//
// Optional feature: define BTN_LONGPRESS_EN to build the long-press detector.
// Without the macro, `long_press` is tied to 0 and no hold counter exists.

module button_step_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int BLINK_CYCLES    = 50_000,
    parameter int LONG_CYCLES     = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic push_button,
    output logic step,
    output logic held,
    output logic led,
    output logic long_press
);

    // Each counter is wide enough to hold its full parameter value.
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int BL_W = $clog2(BLINK_CYCLES + 1);

    // Terminal counts.
    // The debounce counter accepts a change on its DEBOUNCE_CYCLES-th
    // consecutive differing sample.
    // The blink counter spans BLINK_CYCLES cycles per phase.
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_CYCLES - 1);

    // Acknowledge-blink states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } blink_state_t;

    logic              sync1;
    logic              sync2;
    logic [DB_W-1:0]   db_cnt;
    logic              db_done;
    logic              press_accept;

    blink_state_t      state_q;
    blink_state_t      state_d;
    logic [BL_W-1:0]   bl_cnt;
    logic [BL_W-1:0]   bl_cnt_d;
    logic              led_d;

    // Two-flop synchroniser on the inverted key, so a 1 means pressed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= ~push_button;
            sync2 <= sync1;
        end
    end

    // A level change is accepted when the counter has already seen
    // DEBOUNCE_CYCLES-1 differing samples and the current sample also differs.
    // A press is an accepted change toward the pressed level.
    assign db_done      = (sync2 != held) && (db_cnt == DB_LAST);
    assign press_accept = db_done && sync2;

    // Debounce filter: count consecutive samples that differ from the held
    // level. Any sample that agrees with `held` restarts the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            held   <= 1'b0;
            db_cnt <= '0;
        end else if (sync2 == held) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            held   <= sync2;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    // Step pulse: registered copy of the accepted-press strobe, so it rises
    // on the same edge as `held` and lasts exactly one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step <= 1'b0;
        end else begin
            step <= press_accept;
        end
    end

    // Blink FSM next-state logic. Each phase lasts BLINK_CYCLES cycles.
    // A new press always restarts the ON phase from zero.
    always_comb begin
        state_d  = state_q;
        bl_cnt_d = bl_cnt;
        case (state_q)
            ST_IDLE: begin
                bl_cnt_d = '0;
            end
            ST_ON: begin
                if (bl_cnt == BL_LAST) begin
                    state_d  = ST_OFF;
                    bl_cnt_d = '0;
                end else begin
                    bl_cnt_d = bl_cnt + 1'b1;
                end
            end
            ST_OFF: begin
                if (bl_cnt == BL_LAST) begin
                    state_d  = ST_IDLE;
                    bl_cnt_d = '0;
                end else begin
                    bl_cnt_d = bl_cnt + 1'b1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                bl_cnt_d = '0;
            end
        endcase
        if (press_accept) begin
            state_d  = ST_ON;
            bl_cnt_d = '0;
        end
        led_d = (state_d == ST_ON);
    end

    // Blink FSM registers. The LED is decoded from the next state, so it
    // rises on the same edge as `step` and stays glitch-free.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            bl_cnt  <= '0;
            led     <= 1'b0;
        end else begin
            state_q <= state_d;
            bl_cnt  <= bl_cnt_d;
            led     <= led_d;
        end
    end

`ifdef BTN_LONGPRESS_EN
    localparam int LP_W = $clog2(LONG_CYCLES + 1);
    localparam logic [LP_W-1:0] LP_MAX  = LP_W'(LONG_CYCLES);
    localparam logic [LP_W-1:0] LP_LAST = LP_W'(LONG_CYCLES - 1);

    logic [LP_W-1:0] lp_cnt;

    // Hold timer.
    // - It counts cycles since the step edge while the debounced level stays
    //   pressed, then saturates, so only one pulse is fired per press.
    // - The pulse fires on the edge at which the count reaches LONG_CYCLES.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lp_cnt     <= '0;
            long_press <= 1'b0;
        end else begin
            long_press <= held && (lp_cnt == LP_LAST);
            if (!held) begin
                lp_cnt <= '0;
            end else if (lp_cnt != LP_MAX) begin
                lp_cnt <= lp_cnt + 1'b1;
            end
        end
    end
`else
    // With the detector compiled out, LONG_CYCLES only feeds this constant
    // term, which keeps the parameter referenced.
    localparam bit LP_CFG_OK = (LONG_CYCLES >= 1);
    assign long_press = 1'b0 && LP_CFG_OK;
`endif

endmodule
